// File: rtl/clkrst_seq.sv
// Clock divider plus staggered reset sequencer. The divider runs freely. After the external
// request goes quiet, the NUM_RST domain resets release one after another at divided-clock strobes.
module clkrst_seq #(
  parameter int DIV         = 4,
  parameter int RST_CYCLES  = 255,
  parameter int NUM_RST     = 2,
  parameter int STAGGER     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rst_req,
  input  logic               sw_rst,
  output logic               clk_div,
  output logic               clk_en,
  output logic [NUM_RST-1:0] sys_reset,
  output logic               rst_done
);

  localparam int MAX_CNT = RST_CYCLES + (NUM_RST - 1) * STAGGER;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int DW      = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CNT);

  typedef enum logic [1:0] {HOLD, COUNT, RUN} state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic                   clk_div_q, clk_div_d;
  logic                   clk_en_q, clk_en_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [CW-1:0]          seq_cnt_q, seq_cnt_d, seq_cnt_inc;
  logic [NUM_RST-1:0]     sys_reset_q, sys_reset_d;
  logic                   rst_done_q, rst_done_d;
  logic                   restart;
  logic                   last_release;

  assign req_s        = sync_q[SYNC_STAGES-1];
  assign restart      = req_s | sw_rst;
  assign seq_cnt_inc  = (seq_cnt_q == CNT_MAX) ? seq_cnt_q : seq_cnt_q + 1'b1;
  assign last_release = clk_en_q && (seq_cnt_inc == CNT_MAX);

  // clk_div and clk_en are computed from the next count so that they line up with div_cnt_q.
  // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    clk_div_d = (div_cnt_d >= DIV_HALF);
    clk_en_d  = (div_cnt_d == DIV_LAST);
  end

  // NOTE: all state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      clk_div_q   <= 1'b0;
      clk_en_q    <= 1'b0;
      // NOTE: synchroniser flops reset to 1 so the block stays in HOLD until rst_req is seen low.
      sync_q      <= '1;
      state_q     <= HOLD;
      seq_cnt_q   <= '0;
      sys_reset_q <= '1;
      rst_done_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      clk_div_q   <= clk_div_d;
      clk_en_q    <= clk_en_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rst_req};
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      sys_reset_q <= sys_reset_d;
      rst_done_q  <= rst_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = HOLD;
    end else begin
      unique case (state_q)
        HOLD:    if (clk_en_q) state_d = COUNT;
        COUNT:   if (last_release) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = HOLD;
      endcase
    end
  end

  // A restart overrides any release that falls due in the same cycle.
  always_comb begin
    seq_cnt_d   = seq_cnt_q;
    sys_reset_d = sys_reset_q;
    rst_done_d  = rst_done_q;
    if (restart) begin
      seq_cnt_d   = '0;
      sys_reset_d = '1;
      rst_done_d  = 1'b0;
    end else if (state_q == COUNT && clk_en_q) begin
      seq_cnt_d = seq_cnt_inc;
      for (int i = 0; i < NUM_RST; i++) begin
        if (int'(seq_cnt_inc) >= RST_CYCLES + i * STAGGER) sys_reset_d[i] = 1'b0;
      end
      rst_done_d = last_release;
    end
  end

  assign clk_div   = clk_div_q;
  assign clk_en    = clk_en_q;
  assign sys_reset = sys_reset_q;
  assign rst_done  = rst_done_q;

endmodule

// File: tb/tb_clkrst_seq.sv
// Bench for clkrst_seq. Instance a uses the default parameters. Instance b uses the corner
// DIV=2, RST_CYCLES=1, NUM_RST=1, STAGGER=0, and both are compared against a strobe-count model.
module tb_clkrst_seq;

  logic       clk = 1'b0;
  logic       rn [2];
  logic       rq [2];
  logic       sw [2];
  logic       div_a, en_a, done_a;
  logic [1:0] sys_a;
  logic       div_b, en_b, done_b;
  logic [0:0] sys_b;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: edges since reset, rst_req history (bit 1 = synchronised request),
  // and strobes counted since COUNT entry (-1 while holding).
  int         e       [2];
  logic [7:0] hist    [2];
  int         strobes [2];
  // Independent monitor: strobes seen since the request was observed quiet for two edges.
  int         quiet   [2];
  int         armed   [2];

  always #5 clk = ~clk;

  clkrst_seq dut_a (
    .clk(clk), .reset_n(rn[0]), .rst_req(rq[0]), .sw_rst(sw[0]),
    .clk_div(div_a), .clk_en(en_a), .sys_reset(sys_a), .rst_done(done_a)
  );

  clkrst_seq #(.DIV(2), .RST_CYCLES(1), .NUM_RST(1), .STAGGER(0), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset_n(rn[1]), .rst_req(rq[1]), .sw_rst(sw[1]),
    .clk_div(div_b), .clk_en(en_b), .sys_reset(sys_b), .rst_done(done_b)
  );

  function automatic int p_div(int k); return (k == 0) ? 4 : 2;   endfunction
  function automatic int p_rc(int k);  return (k == 0) ? 255 : 1; endfunction
  function automatic int p_nr(int k);  return (k == 0) ? 2 : 1;   endfunction
  function automatic int p_st(int k);  return (k == 0) ? 16 : 0;  endfunction

  function automatic logic [10:0] exp_vec(int k);
    int         ph;
    logic [7:0] s;
    logic       dn;
    ph = e[k] % p_div(k);
    s  = '0;
    for (int i = 0; i < p_nr(k); i++) s[i] = (strobes[k] < p_rc(k) + i * p_st(k));
    dn = (strobes[k] >= p_rc(k) + (p_nr(k) - 1) * p_st(k));
    return {ph >= p_div(k) / 2, ph == p_div(k) - 1, dn, s};
  endfunction

  function automatic logic [10:0] act_vec(int k);
    if (k == 0) return {div_a, en_a, done_a, 6'b0, sys_a};
    return {div_b, en_b, done_b, 7'b0, sys_b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    logic rn_s [2];
    logic rq_s [2];
    logic sw_s [2];
    for (int k = 0; k < 2; k++) begin
      rn_s[k] = rn[k];
      rq_s[k] = rq[k];
      sw_s[k] = sw[k];
      if (!rn[k]) begin
        e[k]       = 0;
        hist[k]    = '1;
        strobes[k] = -1;
      end else begin
        if (hist[k][1] || sw[k]) strobes[k] = -1;
        else if ((e[k] % p_div(k) == p_div(k) - 1) && strobes[k] < 100000) strobes[k]++;
        e[k]++;
        hist[k] = {hist[k][6:0], rq[k]};
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_%0d", k), act_vec(k), exp_vec(k));
      if (!rn_s[k] || rq_s[k]) quiet[k] = 0;
      else quiet[k]++;
      if (!rn_s[k] || sw_s[k] || quiet[k] < 2) armed[k] = 0;
      else if (e[k] % p_div(k) == p_div(k) - 1) armed[k]++;
    end
  endtask

  typedef struct packed {
    logic       rn;
    logic       rq;
    logic       sw;
    logic       div;
    logic       en;
    logic [1:0] sys;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int cyc;
    int a0;
    int b_rel;
    int first;
    logic b_done;

    for (int k = 0; k < 2; k++) begin
      rn[k] = 1'b0; rq[k] = 1'b0; sw[k] = 1'b0;
      e[k] = 0; hist[k] = '1; strobes[k] = -1; quiet[k] = 0; armed[k] = 0;
    end

    // Divider pattern on instance a; restarts in the last rows must not disturb it.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11};

    for (int i = 0; i < 12; i++) begin
      rn[0] = tbl[i].rn; rq[0] = tbl[i].rq; sw[0] = tbl[i].sw;
      tick();
      check($sformatf("tbl_%0d", i), {div_a, en_a, sys_a}, {tbl[i].div, tbl[i].en, tbl[i].sys});
    end
    rq[0] = 1'b0; sw[0] = 1'b0;

    // Power-on sequence for both instances from a fresh reset.
    rn[0] = 1'b0;
    tick();
    rn[0] = 1'b1; rn[1] = 1'b1;
    cyc = 0; a0 = -1; b_rel = -1; b_done = 1'b0;
    while (sys_a[1] !== 1'b0 && cyc < 3000) begin
      tick();
      cyc++;
      if (b_rel < 0 && sys_b[0] === 1'b0) begin b_rel = armed[1]; b_done = done_b; end
      if (a0 < 0 && sys_a[0] === 1'b0) a0 = armed[0];
    end
    // The entry strobe counts as 1, so a release 255 strobes after entry shows up as 256.
    check("por_a_bit0", a0, 256);
    check("por_a_bit1", armed[0], 272);
    check("por_a_bit1_low", sys_a[1], 1'b0);
    check("por_a_done", done_a, 1'b1);
    // The corner instance releases on the second strobe after the request goes quiet.
    check("corner_b_release", b_rel, 2);
    check("corner_b_done", b_done, 1'b1);

    // A 3-cycle rst_req pulse during RUN must reassert everything after the synchroniser.
    rq[0] = 1'b1;
    first = -1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (first < 0 && sys_a === 2'b11 && done_a === 1'b0) first = t;
    end
    rq[0] = 1'b0;
    check("rstreq_latency", first, 3);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 3000) begin tick(); cyc++; end
    check("rstreq_resequence", armed[0], 272);
    check("rstreq_done", done_a, 1'b1);

    // Collision: sw_rst on the strobe that would release bit 0.
    sw[0] = 1'b1; tick(); sw[0] = 1'b0;
    cyc = 0;
    while (armed[0] != 256 && cyc < 3000) begin tick(); cyc++; end
    check("coll_strobe", en_a, 1'b1);
    sw[0] = 1'b1; tick(); sw[0] = 1'b0;
    check("coll_held", sys_a, 2'b11);
    cyc = 0;
    while (sys_a[0] !== 1'b0 && cyc < 3000) begin tick(); cyc++; end
    check("coll_recount", armed[0], 256);

    // Block reset pulse at seq_cnt=100, which is the 101st strobe counting entry as 1.
    cyc = 0;
    while (armed[0] != 101 && cyc < 3000) begin tick(); cyc++; end
    rn[0] = 1'b0; tick();
    check("midrst_outputs", act_vec(0), 11'b000_0000_0011);
    rn[0] = 1'b1;
    cyc = 0;
    while (sys_a[0] !== 1'b0 && cyc < 3000) begin tick(); cyc++; end
    check("midrst_recount", armed[0], 256);

    // Random restarts and resets, compared against the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        int span;
        span  = (k == 0) ? 2999 : 59;
        rq[k] = ($urandom_range(0, span) == 0);
        sw[k] = ($urandom_range(0, span) == 0);
        rn[k] = ($urandom_range(0, span) != 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
